// File: rtl/fmdll_pkg.sv
// Shared FMDLL definitions: checker FSM encoding, period-width helper and
// lock hysteresis defaults used by both the checker and the loop controller.
package fmdll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } chk_state_t;

  localparam int LOCK_CNT_DEF   = 4;
  localparam int UNLOCK_CNT_DEF = 2;

  // Period counter width: two bits of headroom over M so that a 2*(M+1)
  // timeout level always fits.
  function automatic int period_w(input int cnt_w);
    return cnt_w + 2;
  endfunction

endpackage

// File: rtl/div_fall_det.sv
// Two-flop sampler of the active-low divider pulse with a falling-edge strobe.
// History resets high so an idle-high line never produces a spurious edge.
module div_fall_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_div,
  output logic o_fall
);

  logic r_d1;
  logic r_d2;

  // Sample history of the divider output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d1 <= 1'b1;
      r_d2 <= 1'b1;
    end else begin
      r_d1 <= i_div;
      r_d2 <= r_d1;
    end
  end

  assign o_fall = r_d2 & ~r_d1;

endmodule

// File: rtl/div_pulse_checker.sv
// Divide-by-M pulse checker: measures the spacing of divider pulses, flags
// periods that differ from M+1 (or never arrive) and keeps a hysteretic lock.
module div_pulse_checker
  import fmdll_pkg::*;
#(
  parameter int CNT_W      = 2,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
  input  logic               clk_ext,
  input  logic               rst,
  input  logic               en,
  input  logic [CNT_W-1:0]   M,
  input  logic               div_in,
  output logic [CNT_W+1:0]   period_cnt,
  output logic               period_valid,
  output logic               period_err,
  output logic               locked,
  output logic [1:0]         state
);

  localparam int PW = period_w(CNT_W);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};

  logic             w_fall;
  logic [PW-1:0]    w_p;
  logic [PW-1:0]    w_tmo_lvl;
  logic             w_active;
  logic             w_timeout;
  logic             w_event;
  logic             w_good;
  logic             w_m_chg;
  logic             w_go_idle;

  logic [PW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_m_q;
  chk_state_t       r_state;
  logic [GW-1:0]    r_good;
  logic [BW-1:0]    r_bad;
  logic             r_locked;
  logic             r_valid;
  logic             r_err;
  logic [PW-1:0]    r_period_cnt;

  div_fall_det u_fall (
    .i_clk  (clk_ext),
    .i_rst  (rst),
    .i_div  (div_in),
    .o_fall (w_fall)
  );

  // Expected period is M+1 (divider counts 0..M); timeout at twice that
  assign w_p       = PW'(r_m_q) + PW'(1);
  assign w_tmo_lvl = w_p << 1;
  assign w_active  = (r_state == TRACK) || (r_state == LOCKED);
  // A fall landing on the timeout cycle is a measurement, not a timeout
  assign w_timeout = w_active && !w_fall && (r_cnt == w_tmo_lvl);
  assign w_event   = w_fall || w_timeout;
  assign w_good    = w_fall && (r_cnt == w_p);
  assign w_m_chg   = (M != r_m_q);
  // M below 2 means the divider is silent, so there is nothing to check
  assign w_go_idle = !en || (M < CNT_W'(2));

  // Period counter: cleared while idling, reloaded on each edge or timeout, saturating
  always_ff @(posedge clk_ext) begin
    if (rst || w_go_idle) begin
      r_cnt <= '0;
    end else if (w_event) begin
      r_cnt <= PW'(1);
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  // Lock FSM with registered strobes, measurement and lock flag
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      r_state      <= IDLE;
      r_m_q        <= '0;
      r_good       <= '0;
      r_bad        <= '0;
      r_locked     <= 1'b0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_m_q   <= M;
      if (w_go_idle) begin
        r_state  <= IDLE;
        r_locked <= 1'b0;
        r_good   <= '0;
        r_bad    <= '0;
      end else if (w_m_chg || (r_state == IDLE)) begin
        // New ratio: the period in flight is meaningless, start over
        r_state  <= ACQUIRE;
        r_locked <= 1'b0;
        r_good   <= '0;
        r_bad    <= '0;
      end else begin
        case (r_state)
          ACQUIRE: begin
            if (w_fall) r_state <= TRACK;
          end
          TRACK: begin
            if (w_event) begin
              if (w_fall) begin
                r_valid      <= 1'b1;
                r_period_cnt <= r_cnt;
              end
              if (w_good) begin
                if (r_good == GW'(LOCK_CNT - 1)) begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
                  r_good   <= '0;
                  r_bad    <= '0;
                end else begin
                  r_good <= r_good + GW'(1);
                end
              end else begin
                r_err  <= 1'b1;
                r_good <= '0;
              end
            end
          end
          LOCKED: begin
            if (w_event) begin
              if (w_fall) begin
                r_valid      <= 1'b1;
                r_period_cnt <= r_cnt;
              end
              if (w_good) begin
                r_bad <= '0;
              end else begin
                r_err <= 1'b1;
                if (r_bad == BW'(UNLOCK_CNT - 1)) begin
                  r_state  <= TRACK;
                  r_locked <= 1'b0;
                  r_good   <= '0;
                  r_bad    <= '0;
                end else begin
                  r_bad <= r_bad + BW'(1);
                end
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign period_cnt   = r_period_cnt;
  assign period_valid = r_valid;
  assign period_err   = r_err;
  assign locked       = r_locked;
  assign state        = r_state;

endmodule

// File: tb/tb_div_pulse_checker.sv
// Bench for div_pulse_checker: constant vector table, directed corner
// sequences and randomized divider traffic against a timestamp-based model.
module tb_div_pulse_checker;
  import fmdll_pkg::*;

  logic       clk_ext = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] M;
  logic       div_in;
  logic [3:0] period_cnt;
  logic       period_valid;
  logic       period_err;
  logic       locked;
  logic [1:0] state;

  always #5 clk_ext = ~clk_ext;

  div_pulse_checker #(.CNT_W(2), .LOCK_CNT(4), .UNLOCK_CNT(2)) dut (
    .clk_ext      (clk_ext),
    .rst          (rst),
    .en           (en),
    .M            (M),
    .div_in       (div_in),
    .period_cnt   (period_cnt),
    .period_valid (period_valid),
    .period_err   (period_err),
    .locked       (locked),
    .state        (state)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic       g_rst = 1'b1;
  logic       g_en  = 1'b0;
  logic [1:0] g_m   = 2'd0;
  int         g_spent = 0;

  // Reference model: counter kept as a timestamp, lock as run lengths of verdicts
  int m_e = 0;
  int m_z = 0;
  int m_st = 0;
  int m_good_run = 0;
  int m_bad_run = 0;
  int m_mq = 0;
  int m_pcnt = 0;
  bit m_lk = 0, m_v = 0, m_er = 0, m_h1 = 1, m_h2 = 1;

  task automatic model_edge(input logic r, input logic e_n, input logic [1:0] mm, input logic d);
    int cnt;
    int p;
    int verdict;
    bit fall;
    bit tmo;
    bit idle;
    m_e++;
    if (r) begin
      m_st = 0; m_lk = 0; m_good_run = 0; m_bad_run = 0; m_mq = 0;
      m_z = m_e; m_h1 = 1; m_h2 = 1; m_v = 0; m_er = 0; m_pcnt = 0;
      return;
    end
    cnt = (m_e - 1) - m_z;
    if (cnt > 15) cnt = 15;
    fall = m_h2 && !m_h1;
    p = m_mq + 1;
    tmo = (m_st >= 2) && !fall && (cnt == 2 * p);
    idle = !e_n || (int'(mm) < 2);
    if (idle) m_z = m_e;
    else if (fall || tmo) m_z = m_e - 1;
    m_v = 0;
    m_er = 0;
    verdict = 0;
    if (idle) begin
      m_st = 0; m_lk = 0; m_good_run = 0; m_bad_run = 0;
    end else if ((int'(mm) != m_mq) || (m_st == 0)) begin
      m_st = 1; m_lk = 0; m_good_run = 0; m_bad_run = 0;
    end else if (m_st == 1) begin
      if (fall) m_st = 2;
    end else if (fall || tmo) begin
      if (fall) begin m_v = 1; m_pcnt = cnt; end
      verdict = (fall && cnt == p) ? 1 : 2;
      m_er = (verdict == 2);
    end
    if (verdict == 1) begin
      m_bad_run = 0;
      m_good_run++;
      if (!m_lk && m_good_run >= 4) begin m_lk = 1; m_st = 3; m_good_run = 0; end
    end else if (verdict == 2) begin
      m_good_run = 0;
      m_bad_run++;
      if (m_lk && m_bad_run >= 2) begin m_lk = 0; m_st = 2; m_bad_run = 0; end
      if (!m_lk) m_bad_run = 0;
    end
    m_mq = int'(mm);
    m_h2 = m_h1;
    m_h1 = d;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive, let the DUT clock, compare against the model
  task automatic step(input logic d);
    rst = g_rst; en = g_en; M = g_m; div_in = d;
    @(posedge clk_ext);
    #1;
    model_edge(g_rst, g_en, g_m, d);
    n_chk++;
    if (state !== 2'(m_st) || locked !== m_lk || period_valid !== m_v ||
        period_err !== m_er || period_cnt !== 4'(m_pcnt)) begin
      n_fail++;
      $display("FAIL model cyc=%0d got st=%0d lk=%0d v=%0d er=%0d pc=%0d need st=%0d lk=%0d v=%0d er=%0d pc=%0d",
               m_e, state, locked, period_valid, period_err, period_cnt,
               m_st, m_lk, m_v, m_er, m_pcnt);
    end
  endtask

  // Low pulse 'len' cycles after the previous one, then one high cycle where the strobe shows
  task automatic pulse(input int len);
    for (int i = 0; i < len - 1 - g_spent; i++) step(1'b1);
    step(1'b0);
    step(1'b1);
    g_spent = 1;
  endtask

  task automatic do_reset();
    g_rst = 1'b1;
    step(1'b1);
    g_rst = 1'b0;
  endtask

  task automatic lock_up(input logic [1:0] m);
    do_reset();
    g_en = 1'b1;
    g_m  = m;
    step(1'b1);
    g_spent = 0;
    pulse(int'(m) + 1);
    for (int i = 0; i < 4; i++) pulse(int'(m) + 1);
    chk("lock_up_locked", 16'(locked), 16'd1);
  endtask

  typedef struct {
    logic       r;
    logic       en;
    logic [1:0] m;
    logic       d;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic r, input logic e_n, input logic [1:0] m, input logic d,
                              input logic [1:0] st, input logic lk, input logic v,
                              input logic er, input logic [3:0] pc);
    vec_t t;
    t.r = r; t.en = e_n; t.m = m; t.d = d;
    t.exp = {st, lk, v, er, pc};
    return t;
  endfunction

  initial begin
    int hold;
    logic d;
    int ph;

    // Reset, acquire and lock at M=3 with an ideal divider (lows at 3,7,11,15,19)
    tbl[0]  = mk(1, 0, 3, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 3, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 3, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 3, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 3, 1, 2, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 3, 1, 2, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 3, 1, 2, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 3, 0, 2, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 3, 1, 2, 0, 1, 0, 4);
    tbl[9]  = mk(0, 1, 3, 1, 2, 0, 0, 0, 4);
    tbl[10] = mk(0, 1, 3, 1, 2, 0, 0, 0, 4);
    tbl[11] = mk(0, 1, 3, 0, 2, 0, 0, 0, 4);
    tbl[12] = mk(0, 1, 3, 1, 2, 0, 1, 0, 4);
    tbl[13] = mk(0, 1, 3, 1, 2, 0, 0, 0, 4);
    tbl[14] = mk(0, 1, 3, 1, 2, 0, 0, 0, 4);
    tbl[15] = mk(0, 1, 3, 0, 2, 0, 0, 0, 4);
    tbl[16] = mk(0, 1, 3, 1, 2, 0, 1, 0, 4);
    tbl[17] = mk(0, 1, 3, 1, 2, 0, 0, 0, 4);
    tbl[18] = mk(0, 1, 3, 1, 2, 0, 0, 0, 4);
    tbl[19] = mk(0, 1, 3, 0, 2, 0, 0, 0, 4);
    tbl[20] = mk(0, 1, 3, 1, 3, 1, 1, 0, 4);
    tbl[21] = mk(0, 1, 3, 1, 3, 1, 0, 0, 4);

    rst = 1'b1; en = 1'b0; M = 2'd0; div_in = 1'b1;

    for (int i = 0; i < 22; i++) begin
      g_rst = tbl[i].r; g_en = tbl[i].en; g_m = tbl[i].m;
      step(tbl[i].d);
      chk($sformatf("tbl[%0d]", i),
          16'({state, locked, period_valid, period_err, period_cnt}), 16'(tbl[i].exp));
    end

    // Early pulses while locked at M=3: first keeps lock, second drops it
    lock_up(2'd3);
    pulse(3);
    chk("early1_err", 16'({period_valid, period_err}), 16'b11);
    chk("early1_pcnt", 16'(period_cnt), 16'd3);
    chk("early1_lock", 16'({state, locked}), 16'({2'd3, 1'b1}));
    pulse(3);
    chk("early2_err", 16'(period_err), 16'd1);
    chk("early2_unlock", 16'({state, locked}), 16'({2'd2, 1'b0}));

    // Locked at M=2, line stuck high: timeouts every 6 cycles
    lock_up(2'd2);
    for (int i = 2; i <= 13; i++) begin
      step(1'b1);
      chk($sformatf("tmo_err[%0d]", i), 16'({period_valid, period_err}),
          16'({1'b0, (i == 7) || (i == 13)}));
      if (i == 7)  chk("tmo_still_locked", 16'({state, locked}), 16'({2'd3, 1'b1}));
      if (i == 13) chk("tmo_unlocked", 16'({state, locked}), 16'({2'd2, 1'b0}));
    end

    // Ratio change 3 -> 2 while locked, then relock on periods of 3
    lock_up(2'd3);
    g_m = 2'd2;
    step(1'b1);
    chk("mchg_state", 16'({state, locked}), 16'({2'd1, 1'b0}));
    g_spent = 2;
    pulse(3);
    chk("mchg_partial", 16'({state, period_valid, period_err}), 16'({2'd2, 2'b00}));
    for (int i = 0; i < 4; i++) begin
      pulse(3);
      chk($sformatf("relock_pcnt[%0d]", i), 16'({period_valid, period_cnt}), 16'({1'b1, 4'd3}));
      chk($sformatf("relock_lk[%0d]", i), 16'(locked), 16'(i == 3));
    end

    // Ratio change on the same cycle the fall is seen: no strobe
    lock_up(2'd3);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    g_m = 2'd2;
    step(1'b1);
    chk("mchg_fall", 16'({state, locked, period_valid, period_err}), 16'({2'd1, 3'b000}));

    // Silent divider ratios and disabled checker stay idle
    do_reset();
    for (int k = 0; k < 3; k++) begin
      g_en = (k != 2);
      g_m  = (k == 2) ? 2'd3 : 2'(k);
      for (int i = 0; i < 12; i++) begin
        step((i % 4) != 3);
        chk($sformatf("idle[%0d][%0d]", k, i),
            16'({state, locked, period_valid, period_err}), 16'd0);
      end
    end

    // Reset in the middle of tracking
    do_reset();
    g_en = 1'b1; g_m = 2'd3;
    step(1'b1);
    g_spent = 0;
    pulse(4);
    pulse(4);
    chk("pre_rst_track", 16'({state, period_cnt}), 16'({2'd2, 4'd4}));
    g_rst = 1'b1;
    step(1'b1);
    g_rst = 1'b0;
    chk("mid_rst", 16'({state, locked, period_valid, period_err, period_cnt}), 16'd0);

    // Pulse arriving exactly when the counter reaches 2*P (M=2)
    g_en = 1'b1; g_m = 2'd2;
    step(1'b1);
    g_spent = 0;
    pulse(3);
    pulse(3);
    chk("edge_good", 16'({period_valid, period_err, period_cnt}), 16'({2'b10, 4'd3}));
    pulse(6);
    chk("edge_2p", 16'({period_valid, period_err, period_cnt}), 16'({2'b11, 4'd6}));
    pulse(3);
    chk("edge_after", 16'({period_valid, period_err, period_cnt}), 16'({2'b10, 4'd3}));

    // Randomized divider traffic with jitter, dropouts, ratio changes, enables and resets
    do_reset();
    g_en = 1'b1; g_m = 2'd3;
    ph = 0;
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      g_rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) g_en = ~g_en;
      if (!g_en && $urandom_range(0, 9) == 0) g_en = 1'b1;
      if ($urandom_range(0, 299) == 0) g_m = 2'($urandom_range(0, 3));
      if (ph >= int'(g_m)) ph = 0;
      else ph++;
      d = !((ph == int'(g_m)) && (g_m >= 2'd2));
      if ($urandom_range(0, 39) == 0) d = ~d;
      if (hold == 0 && $urandom_range(0, 299) == 0) hold = $urandom_range(8, 20);
      if (hold > 0) begin
        d = 1'b1;
        hold--;
      end
      step(d);
    end
    g_rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
